dcpl_drain_ctrl: RTL and testbench
==================================

Name: dcpl_drain_ctrl

Overview:
Generates the decouple control for the static decoupler stage. It drains in-flight DMA traffic from the dynamic region before asserting decouple, and sequences recoupling after reconfiguration. It sits between the static control registers and the s_decouple input of the static decoupler. It monitors per-channel DMA read/write request handshakes and their completions, and gates new requests while draining.

Parameters:
N_SCHAN, 2, number of stream/DMA channels monitored
CNT_BITS, 6, width of each outstanding-transaction counter
TMO_BITS, 16, width of drain timeout counter
TMO_CYCLES, 50000, drain cycles before a forced decouple
SETTLE_CYCLES, 4, cycles that hold stays asserted after decouple drops (covers register-slice depth)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_dcpl_req  in  1  single-cycle pulse: request decouple
s_rcpl_req  in  1  single-cycle pulse: request recouple
rd_issue  in  N_SCHAN  per-channel DMA read request handshake (valid&ready) pulse
rd_done  in  N_SCHAN  per-channel DMA read completion pulse
wr_issue  in  N_SCHAN  per-channel DMA write request handshake pulse
wr_done  in  N_SCHAN  per-channel DMA write completion pulse
m_decouple  out  1  drives s_decouple of the static decoupler
m_hold  out  1  blocks new DMA requests from the dynamic region (gates ready upstream)
m_busy  out  1  high in DRAIN or SETTLE
m_state  out  2  encoded FSM state
m_tmo  out  1  sticky: last drain ended by timeout
m_err  out  1  sticky: counter overflow or underflow
m_outstanding  out  1  OR of all counters non-zero

Behaviour:
- Reset (async, any state): FSM=COUPLED; counters=0; timeout counter=0; settle counter=0; m_decouple=0; m_hold=0; m_busy=0; m_tmo=0; m_err=0; m_state=2'd0.
- All outputs are registered. Every state-derived output changes in the cycle after the transition condition is sampled.
- States (m_state encoding): COUPLED=0, DRAIN=1, DECOUPLED=2, SETTLE=3.
- COUPLED: hold=0, decouple=0.
  - s_dcpl_req -> DRAIN. Clears m_tmo and the timeout counter.
  - s_rcpl_req is ignored.
- DRAIN: hold=1, decouple=0, busy=1. The timeout counter increments each cycle.
  - All counters zero (registered values) -> DECOUPLED.
  - Otherwise, timeout counter == TMO_CYCLES-1 -> DECOUPLED and m_tmo set.
  - If both conditions hold in the same cycle, the clean drain wins and m_tmo stays 0.
  - s_dcpl_req is ignored. s_rcpl_req aborts to SETTLE; decouple never rises.
- DECOUPLED: hold=1, decouple=1.
  - s_rcpl_req -> SETTLE. Settle counter loads SETTLE_CYCLES-1.
  - s_dcpl_req is ignored.
- SETTLE: decouple=0, hold=1, busy=1. The settle counter decrements.
  - At 0 -> COUPLED. All outstanding counters clear to 0 in that transition cycle, because completions lost across reconfiguration are discarded.
  - Requests in SETTLE are ignored.
- Counters (one per channel per direction, CNT_BITS wide):
  - issue only: +1. done only: -1. Both in the same cycle: unchanged.
  - issue at all-ones: counter holds and m_err is set.
  - done at zero: counter holds and m_err is set.
  - Counting continues in every state, including DECOUPLED.
- m_outstanding is registered. It is the OR-reduce of the next-state counter values.
- m_err clears only on reset.
- Issue pulses while hold=1 are still counted. The gating latency is one cycle, so one request may slip through in the cycle DRAIN is entered.
- Drain-to-decouple latency: 1 cycle after the counters reach zero.

Test Plan:
- Idle drain: all counters 0; pulse s_dcpl_req at t0 -> m_hold=1 at t0+1, m_state=2 and m_decouple=1 at t0+2, m_tmo=0.
- Outstanding drain: 3 rd_issue on ch0, then s_dcpl_req, then rd_done on ch0 at +10/+20/+30 -> m_decouple rises 1 cycle after the third done; m_outstanding falls with it.
- Timeout: TMO_CYCLES=100; 1 wr_issue on ch1 never completed; s_dcpl_req -> m_decouple=1 exactly 100 cycles after DRAIN entry, m_tmo=1; then s_rcpl_req -> m_decouple=0 next cycle, m_hold=0 after 4 more cycles, m_outstanding=0.
- Simultaneous issue and done on ch0 with count=2 -> count stays 2; done with count 0 -> m_err=1, count stays 0; 64 issues with CNT_BITS=6 -> m_err=1, count holds at 63.
- Abort and reset: s_rcpl_req during DRAIN -> SETTLE, m_decouple never asserts. Assert areset mid-DRAIN for 1 cycle asynchronously -> all outputs return to 0 immediately, state COUPLED.

Source files
------------

// File: rtl/dcpl_drain_ctrl_if.sv
// Handshake bundle between the static control registers, the DMA monitors
// and the decouple controller.
interface dcpl_drain_ctrl_if #(
   parameter int unsigned N_SCHAN = 2
);
   logic               s_dcpl_req;
   logic               s_rcpl_req;
   logic [N_SCHAN-1:0] rd_issue;
   logic [N_SCHAN-1:0] rd_done;
   logic [N_SCHAN-1:0] wr_issue;
   logic [N_SCHAN-1:0] wr_done;
   logic               m_decouple;
   logic               m_hold;
   logic               m_busy;
   logic [1:0]         m_state;
   logic               m_tmo;
   logic               m_err;
   logic               m_outstanding;

   // Requester / monitor side
   modport master (
      output s_dcpl_req, s_rcpl_req, rd_issue, rd_done, wr_issue, wr_done,
      input  m_decouple, m_hold, m_busy, m_state, m_tmo, m_err, m_outstanding
   );

   // Controller side
   modport slave (
      input  s_dcpl_req, s_rcpl_req, rd_issue, rd_done, wr_issue, wr_done,
      output m_decouple, m_hold, m_busy, m_state, m_tmo, m_err, m_outstanding
   );
endinterface

// File: rtl/dcpl_drain_ctrl.sv
// Decouple controller: drains outstanding DMA traffic before decoupling the
// dynamic region and sequences the settle period on recouple.
module dcpl_drain_ctrl #(
   parameter int unsigned N_SCHAN       = 2,
   parameter int unsigned CNT_BITS      = 6,
   parameter int unsigned TMO_BITS      = 16,
   parameter int unsigned TMO_CYCLES    = 50000,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic             aclk,
   input logic             areset,
   dcpl_drain_ctrl_if.slave bus
);

   localparam int unsigned SET_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TMO_CYCLES - 1);
   localparam logic [SET_BITS-1:0] SET_LOAD = SET_BITS'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_COUPLED   = 2'd0,
      ST_DRAIN     = 2'd1,
      ST_DECOUPLED = 2'd2,
      ST_SETTLE    = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [TMO_BITS-1:0] tmo_cnt;
   logic [TMO_BITS-1:0] tmo_cnt_nxt;
   logic [SET_BITS-1:0] set_cnt;
   logic [SET_BITS-1:0] set_cnt_nxt;
   logic                tmo_flag_nxt;
   logic                cnt_clr;

   logic [CNT_BITS-1:0] rd_cnt     [N_SCHAN];
   logic [CNT_BITS-1:0] wr_cnt     [N_SCHAN];
   logic [CNT_BITS-1:0] rd_cnt_nxt [N_SCHAN];
   logic [CNT_BITS-1:0] wr_cnt_nxt [N_SCHAN];
   logic [CNT_BITS:0]   rd_step;
   logic [CNT_BITS:0]   wr_step;
   logic                all_zero;
   logic                err_hit;
   logic                outst_nxt;

   // One counter update: returns {error, next_count}; saturates on both ends
   function automatic logic [CNT_BITS:0] cnt_step(
      input logic [CNT_BITS-1:0] c,
      input logic                iss,
      input logic                dn
   );
      logic [CNT_BITS-1:0] r;
      logic                e;
      r = c;
      e = 1'b0;
      if (iss && !dn) begin
         if (c == '1) e = 1'b1;
         else         r = c + CNT_BITS'(1);
      end else if (dn && !iss) begin
         if (c == '0) e = 1'b1;
         else         r = c - CNT_BITS'(1);
      end
      return {e, r};
   endfunction

   // Completions lost across reconfiguration are discarded on the way back to COUPLED
   assign cnt_clr = (state == ST_SETTLE) && (set_cnt == '0);

   // Outstanding-transaction counter next state, error detection and idle detect
   always_comb begin
      rd_cnt_nxt = rd_cnt;
      wr_cnt_nxt = wr_cnt;
      rd_step    = '0;
      wr_step    = '0;
      err_hit    = 1'b0;
      all_zero   = 1'b1;
      outst_nxt  = 1'b0;
      for (int i = 0; i < N_SCHAN; i++) begin
         if ((rd_cnt[i] != '0) || (wr_cnt[i] != '0)) all_zero = 1'b0;
         rd_step       = cnt_step(rd_cnt[i], bus.rd_issue[i], bus.rd_done[i]);
         wr_step       = cnt_step(wr_cnt[i], bus.wr_issue[i], bus.wr_done[i]);
         rd_cnt_nxt[i] = rd_step[CNT_BITS-1:0];
         wr_cnt_nxt[i] = wr_step[CNT_BITS-1:0];
         err_hit       = err_hit | rd_step[CNT_BITS] | wr_step[CNT_BITS];
         if (cnt_clr) begin
            rd_cnt_nxt[i] = '0;
            wr_cnt_nxt[i] = '0;
         end
         if ((rd_cnt_nxt[i] != '0) || (wr_cnt_nxt[i] != '0)) outst_nxt = 1'b1;
      end
   end

   // Next-state logic with drain timeout and settle countdown
   always_comb begin
      state_nxt    = state;
      tmo_cnt_nxt  = tmo_cnt;
      set_cnt_nxt  = set_cnt;
      tmo_flag_nxt = bus.m_tmo;
      unique case (state)
         ST_COUPLED: begin
            if (bus.s_dcpl_req) begin
               state_nxt    = ST_DRAIN;
               tmo_cnt_nxt  = '0;
               tmo_flag_nxt = 1'b0;
            end
         end
         ST_DRAIN: begin
            tmo_cnt_nxt = tmo_cnt + TMO_BITS'(1);
            if (bus.s_rcpl_req) begin
               state_nxt   = ST_SETTLE;
               set_cnt_nxt = SET_LOAD;
            end else if (all_zero) begin
               state_nxt = ST_DECOUPLED;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt    = ST_DECOUPLED;
               tmo_flag_nxt = 1'b1;
            end
         end
         ST_DECOUPLED: begin
            if (bus.s_rcpl_req) begin
               state_nxt   = ST_SETTLE;
               set_cnt_nxt = SET_LOAD;
            end
         end
         ST_SETTLE: begin
            if (set_cnt == '0) state_nxt = ST_COUPLED;
            else               set_cnt_nxt = set_cnt - SET_BITS'(1);
         end
         default: state_nxt = ST_COUPLED;
      endcase
   end

   // State register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= ST_COUPLED;
      else        state <= state_nxt;
   end

   assign bus.m_state = state;

   // Counters, timers and registered status outputs
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         tmo_cnt           <= '0;
         set_cnt           <= '0;
         rd_cnt            <= '{default: '0};
         wr_cnt            <= '{default: '0};
         bus.m_decouple    <= 1'b0;
         bus.m_hold        <= 1'b0;
         bus.m_busy        <= 1'b0;
         bus.m_tmo         <= 1'b0;
         bus.m_err         <= 1'b0;
         bus.m_outstanding <= 1'b0;
      end else begin
         tmo_cnt           <= tmo_cnt_nxt;
         set_cnt           <= set_cnt_nxt;
         rd_cnt            <= rd_cnt_nxt;
         wr_cnt            <= wr_cnt_nxt;
         bus.m_decouple    <= (state_nxt == ST_DECOUPLED);
         bus.m_hold        <= (state_nxt != ST_COUPLED);
         bus.m_busy        <= (state_nxt == ST_DRAIN) || (state_nxt == ST_SETTLE);
         bus.m_tmo         <= tmo_flag_nxt;
         bus.m_err         <= bus.m_err | err_hit;
         bus.m_outstanding <= outst_nxt;
      end
   end

endmodule

// File: tb/tb_dcpl_drain_ctrl.sv
// Directed bench for dcpl_drain_ctrl with a scoreboard of expected outputs.
module tb_dcpl_drain_ctrl;

   localparam int unsigned N_SCHAN       = 2;
   localparam int unsigned CNT_BITS      = 6;
   localparam int unsigned TMO_BITS      = 16;
   localparam int unsigned TMO_CYCLES    = 100;
   localparam int unsigned SETTLE_CYCLES = 4;

   localparam logic [1:0] S_CPL = 2'd0;
   localparam logic [1:0] S_DRN = 2'd1;
   localparam logic [1:0] S_DEC = 2'd2;
   localparam logic [1:0] S_SET = 2'd3;

   typedef struct packed {
      logic       dec;
      logic       hold;
      logic       busy;
      logic [1:0] st;
      logic       tmo;
      logic       err;
      logic       outst;
   } outs_t;

   typedef struct {
      string tag;
      outs_t exp;
   } sb_t;

   logic aclk;
   logic areset;

   dcpl_drain_ctrl_if #(.N_SCHAN(N_SCHAN)) bus ();

   dcpl_drain_ctrl #(
      .N_SCHAN      (N_SCHAN),
      .CNT_BITS     (CNT_BITS),
      .TMO_BITS     (TMO_BITS),
      .TMO_CYCLES   (TMO_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .aclk  (aclk),
      .areset(areset),
      .bus   (bus)
   );

   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic e_tmo = 1'b0;
   logic e_err = 1'b0;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Expected outputs from the state encoding and the tracked sticky flags
   function automatic outs_t mk(input logic [1:0] st, input logic outst);
      outs_t r;
      r.dec   = (st == S_DEC);
      r.hold  = (st != S_CPL);
      r.busy  = (st == S_DRN) || (st == S_SET);
      r.st    = st;
      r.tmo   = e_tmo;
      r.err   = e_err;
      r.outst = outst;
      return r;
   endfunction

   function automatic outs_t obs();
      outs_t r;
      r.dec   = bus.m_decouple;
      r.hold  = bus.m_hold;
      r.busy  = bus.m_busy;
      r.st    = bus.m_state;
      r.tmo   = bus.m_tmo;
      r.err   = bus.m_err;
      r.outst = bus.m_outstanding;
      return r;
   endfunction

   task automatic clear_inputs();
      bus.s_dcpl_req = 1'b0;
      bus.s_rcpl_req = 1'b0;
      bus.rd_issue   = '0;
      bus.rd_done    = '0;
      bus.wr_issue   = '0;
      bus.wr_done    = '0;
   endtask

   task automatic compare_front();
      sb_t   s;
      outs_t o;
      s = sb_q.pop_front();
      o = obs();
      n_cmp++;
      assert (o === s.exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b (dec,hold,busy,st[2],tmo,err,outst)",
                s.tag, o, s.exp);
      end
   endtask

   // Drive the current inputs for one cycle, then check the registered outputs
   task automatic cyc(input string tag, input logic [1:0] st, input logic outst);
      sb_q.push_back('{tag, mk(st, outst)});
      @(posedge aclk);
      #1;
      compare_front();
      clear_inputs();
   endtask

   // Check outputs without advancing the clock
   task automatic now_chk(input string tag, input logic [1:0] st, input logic outst);
      sb_q.push_back('{tag, mk(st, outst)});
      compare_front();
   endtask

   initial begin
      areset = 1'b1;
      clear_inputs();
      #12;
      now_chk("reset", S_CPL, 1'b0);
      areset = 1'b0;

      // Idle drain and recouple
      bus.s_dcpl_req = 1'b1; cyc("idle_enter", S_DRN, 1'b0);
      cyc("idle_decoupled", S_DEC, 1'b0);
      bus.s_dcpl_req = 1'b1; cyc("dcpl_ignored", S_DEC, 1'b0);
      bus.s_rcpl_req = 1'b1; cyc("idle_settle", S_SET, 1'b0);
      for (int i = 0; i < 3; i++) cyc("idle_settling", S_SET, 1'b0);
      cyc("idle_recoupled", S_CPL, 1'b0);
      bus.s_rcpl_req = 1'b1; cyc("rcpl_ignored", S_CPL, 1'b0);

      // Drain with three outstanding reads completing at +10/+20/+30
      for (int i = 0; i < 3; i++) begin
         bus.rd_issue = 2'b01; cyc("rd_issue", S_CPL, 1'b1);
      end
      bus.s_dcpl_req = 1'b1; cyc("drain_enter", S_DRN, 1'b1);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 9; j++) cyc("drain_wait", S_DRN, 1'b1);
         bus.rd_done = 2'b01;
         cyc((k < 2) ? "drain_done" : "drain_last_done", S_DRN, (k < 2));
      end
      cyc("drain_clean", S_DEC, 1'b0);
      bus.s_rcpl_req = 1'b1; cyc("drain_settle", S_SET, 1'b0);
      for (int i = 0; i < 3; i++) cyc("drain_settling", S_SET, 1'b0);
      cyc("drain_recoupled", S_CPL, 1'b0);

      // Timeout with a write on ch1 that never completes
      bus.wr_issue = 2'b10; cyc("wr_issue_ch1", S_CPL, 1'b1);
      bus.s_dcpl_req = 1'b1; cyc("tmo_enter", S_DRN, 1'b1);
      for (int i = 0; i < 99; i++) cyc("tmo_wait", S_DRN, 1'b1);
      e_tmo = 1'b1;
      cyc("tmo_fire", S_DEC, 1'b1);
      bus.s_rcpl_req = 1'b1; cyc("tmo_settle", S_SET, 1'b1);
      for (int i = 0; i < 3; i++) cyc("tmo_settling", S_SET, 1'b1);
      cyc("tmo_recoupled", S_CPL, 1'b0);

      // Abort drain with recouple; decouple must never rise
      bus.rd_issue = 2'b10; cyc("abort_issue", S_CPL, 1'b1);
      e_tmo = 1'b0;
      bus.s_dcpl_req = 1'b1; cyc("abort_enter", S_DRN, 1'b1);
      cyc("abort_draining", S_DRN, 1'b1);
      bus.s_rcpl_req = 1'b1; cyc("abort_settle", S_SET, 1'b1);
      for (int i = 0; i < 3; i++) cyc("abort_settling", S_SET, 1'b1);
      cyc("abort_recoupled", S_CPL, 1'b0);

      // Simultaneous issue/done and underflow on ch0
      bus.rd_issue = 2'b01; cyc("cnt_to1", S_CPL, 1'b1);
      bus.rd_issue = 2'b01; cyc("cnt_to2", S_CPL, 1'b1);
      bus.rd_issue = 2'b01; bus.rd_done = 2'b01; cyc("iss_done_same", S_CPL, 1'b1);
      bus.rd_done = 2'b01; cyc("done_to1", S_CPL, 1'b1);
      bus.rd_done = 2'b01; cyc("done_to0", S_CPL, 1'b0);
      e_err = 1'b1;
      bus.rd_done = 2'b01; cyc("underflow", S_CPL, 1'b0);
      cyc("err_sticky", S_CPL, 1'b0);

      // Asynchronous reset in the middle of a drain
      bus.wr_issue = 2'b01; cyc("rst_issue", S_CPL, 1'b1);
      bus.s_dcpl_req = 1'b1; cyc("rst_drain", S_DRN, 1'b1);
      cyc("rst_draining", S_DRN, 1'b1);
      #2;
      areset = 1'b1;
      #1;
      e_err = 1'b0;
      e_tmo = 1'b0;
      now_chk("async_reset", S_CPL, 1'b0);
      #7;
      areset = 1'b0;
      cyc("post_reset", S_CPL, 1'b0);

      // Overflow: 64 issues saturate at 63, then 63 completions empty it
      for (int i = 0; i < 63; i++) begin
         bus.wr_issue = 2'b01; cyc("ovf_fill", S_CPL, 1'b1);
      end
      e_err = 1'b1;
      bus.wr_issue = 2'b01; cyc("overflow", S_CPL, 1'b1);
      for (int i = 0; i < 62; i++) begin
         bus.wr_done = 2'b01; cyc("ovf_drain", S_CPL, 1'b1);
      end
      bus.wr_done = 2'b01; cyc("ovf_empty", S_CPL, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
